srg_id_ex_stage: RTL and testbench

SRG_ID_EX_STAGE -- requirements
Module: srg_id_ex_stage

---
 rtl/srg_alu_pkg.sv | 37 +++
 rtl/srg_alu_ctrl.sv | 49 ++++
 rtl/srg_id_ex_stage.sv | 133 +++++++++++++
 tb/tb_srg_id_ex_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srg_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : srg_alu_pkg
//  Purpose  : Shared ALU constants for the ID/EX stage. Holds the
//             OperationSelect encodings, the alu_op codes coming from the main
//             decoder, and the R-type funct values recognised by the ALU
//             control decoder.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package srg_alu_pkg;

   // OperationSelect: bit2 invert-B/carry-in, bit1 arithmetic/logic,
   // bit0 or/slt select.
   typedef enum logic [2:0] {
      C_SEL_AND = 3'b000,
      C_SEL_OR  = 3'b001,
      C_SEL_ADD = 3'b010,
      C_SEL_SUB = 3'b110,
      C_SEL_SLT = 3'b111
   } alu_sel_e;

   // alu_op codes from the main decoder.
   localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
   localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
   localparam logic [1:0] C_ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] C_ALUOP_RSVD  = 2'b11;

   // R-type funct field values.
   localparam logic [5:0] C_FUNCT_ADD = 6'b100000;
   localparam logic [5:0] C_FUNCT_SUB = 6'b100010;
   localparam logic [5:0] C_FUNCT_AND = 6'b100100;
   localparam logic [5:0] C_FUNCT_OR  = 6'b100101;
   localparam logic [5:0] C_FUNCT_SLT = 6'b101010;

endpackage : srg_alu_pkg
`default_nettype wire

// File: rtl/srg_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : srg_alu_ctrl
//  Purpose  : Combinational ALU control decoder. Maps (alu_op, funct) to the
//             3-bit OperationSelect and flags unrecognised encodings.
//  Ports    : i_alu_op  [1:0] main-decoder ALU operation class
//             i_funct   [5:0] R-type function field
//             o_alu_sel [2:0] OperationSelect
//             o_illegal       unrecognised alu_op/funct (selects ADD)
//  Revision : 1.0  initial release
// ============================================================================
module srg_alu_ctrl
   import srg_alu_pkg::*;
(
   input  logic [1:0] i_alu_op,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alu_sel,
   output logic       o_illegal
);

   always_comb begin
      o_alu_sel = C_SEL_ADD;
      o_illegal = 1'b0;
      case (i_alu_op)
         C_ALUOP_ADD: o_alu_sel = C_SEL_ADD;
         C_ALUOP_SUB: o_alu_sel = C_SEL_SUB;
         C_ALUOP_RTYPE: begin
            case (i_funct)
               C_FUNCT_ADD: o_alu_sel = C_SEL_ADD;
               C_FUNCT_SUB: o_alu_sel = C_SEL_SUB;
               C_FUNCT_AND: o_alu_sel = C_SEL_AND;
               C_FUNCT_OR:  o_alu_sel = C_SEL_OR;
               C_FUNCT_SLT: o_alu_sel = C_SEL_SLT;
               default: begin
                  o_alu_sel = C_SEL_ADD;
                  o_illegal = 1'b1;
               end
            endcase
         end
         default: begin
            // Reserved alu_op: harmless ADD, flagged illegal.
            o_alu_sel = C_SEL_ADD;
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule : srg_alu_ctrl
`default_nettype wire

// File: rtl/srg_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : srg_id_ex_stage
//  Purpose  : ID/EX pipeline register with operand forwarding and ALU control
//             decode. One-entry valid/ready register; forwarding and decode
//             are resolved in the capture cycle only.
//  Ports    : clk, rst_n (async, active-low)
//             i_in_valid / o_in_ready          upstream handshake
//             i_rs_data, i_rt_data, i_imm      operand sources
//             i_rs_addr, i_rt_addr, i_rd_addr  register numbers
//             i_alu_src, i_alu_op, i_funct     operand/ALU decode controls
//             i_wr_en, i_flush                 writeback enable, kill
//             i_exmem_*, i_memwb_*             forwarding sources
//             o_out_valid / i_out_ready        downstream handshake
//             o_alu_a, o_alu_b, o_alu_sel      registered ALU inputs
//             o_out_rd, o_out_wr_en, o_illegal registered writeback info
//  Revision : 1.0  initial release
// ============================================================================
module srg_id_ex_stage
   import srg_alu_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_in_valid,
   output logic          o_in_ready,
   input  logic [DW-1:0] i_rs_data,
   input  logic [DW-1:0] i_rt_data,
   input  logic [DW-1:0] i_imm,
   input  logic [RW-1:0] i_rs_addr,
   input  logic [RW-1:0] i_rt_addr,
   input  logic [RW-1:0] i_rd_addr,
   input  logic          i_alu_src,
   input  logic [1:0]    i_alu_op,
   input  logic [5:0]    i_funct,
   input  logic          i_wr_en,
   input  logic          i_flush,
   input  logic          i_exmem_wr_en,
   input  logic          i_memwb_wr_en,
   input  logic [RW-1:0] i_exmem_rd,
   input  logic [RW-1:0] i_memwb_rd,
   input  logic [DW-1:0] i_exmem_result,
   input  logic [DW-1:0] i_memwb_result,
   output logic          o_out_valid,
   input  logic          i_out_ready,
   output logic [DW-1:0] o_alu_a,
   output logic [DW-1:0] o_alu_b,
   output logic [2:0]    o_alu_sel,
   output logic [RW-1:0] o_out_rd,
   output logic          o_out_wr_en,
   output logic          o_illegal
);

   logic          r_valid;
   logic [DW-1:0] r_alu_a;
   logic [DW-1:0] r_alu_b;
   logic [2:0]    r_alu_sel;
   logic [RW-1:0] r_rd;
   logic          r_wr_en;
   logic          r_illegal;

   logic [DW-1:0] w_fwd_a;
   logic [DW-1:0] w_fwd_b;
   logic [DW-1:0] w_op_b;
   logic [2:0]    w_alu_sel;
   logic          w_illegal;
   logic          w_in_ready;
   logic          w_capture;

   srg_alu_ctrl u_alu_ctrl (
      .i_alu_op  (i_alu_op),
      .i_funct   (i_funct),
      .o_alu_sel (w_alu_sel),
      .o_illegal (w_illegal)
   );

   // Forwarding: EX/MEM beats MEM/WB; register 0 is never forwarded.
   always_comb begin
      w_fwd_a = i_rs_data;
      if (i_exmem_wr_en && (i_exmem_rd == i_rs_addr) && (i_rs_addr != '0))
         w_fwd_a = i_exmem_result;
      else if (i_memwb_wr_en && (i_memwb_rd == i_rs_addr) && (i_rs_addr != '0))
         w_fwd_a = i_memwb_result;

      w_fwd_b = i_rt_data;
      if (i_exmem_wr_en && (i_exmem_rd == i_rt_addr) && (i_rt_addr != '0))
         w_fwd_b = i_exmem_result;
      else if (i_memwb_wr_en && (i_memwb_rd == i_rt_addr) && (i_rt_addr != '0))
         w_fwd_b = i_memwb_result;
   end

   assign w_op_b     = i_alu_src ? i_imm : w_fwd_b;
   assign w_in_ready = !r_valid || i_out_ready;
   assign w_capture  = i_in_valid && w_in_ready;

   // Flush dominates capture; data fields only ever change on capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_sel <= '0;
         r_rd      <= '0;
         r_wr_en   <= 1'b0;
         r_illegal <= 1'b0;
      end else if (i_flush) begin
         r_valid   <= 1'b0;
      end else if (w_capture) begin
         r_valid   <= 1'b1;
         r_alu_a   <= w_fwd_a;
         r_alu_b   <= w_op_b;
         r_alu_sel <= w_alu_sel;
         r_rd      <= i_rd_addr;
         r_wr_en   <= i_wr_en && !w_illegal;
         r_illegal <= w_illegal;
      end else if (r_valid && i_out_ready) begin
         r_valid   <= 1'b0;
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = r_valid;
   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_sel   = r_alu_sel;
   assign o_out_rd    = r_rd;
   assign o_out_wr_en = r_wr_en;
   assign o_illegal   = r_illegal;

endmodule : srg_id_ex_stage
`default_nettype wire

// File: tb/tb_srg_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_srg_id_ex_stage
//  Purpose  : Self-checking bench for srg_id_ex_stage: directed scenarios plus
//             randomized traffic checked against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_srg_id_ex_stage;

   localparam int DW = 32;
   localparam int RW = 5;

   typedef struct {
      logic          in_valid;
      logic [DW-1:0] rs_data, rt_data, imm;
      logic [RW-1:0] rs, rt, rd;
      logic          alu_src;
      logic [1:0]    alu_op;
      logic [5:0]    funct;
      logic          wr_en, flush;
      logic          exwe, mwwe;
      logic [RW-1:0] exrd, mwrd;
      logic [DW-1:0] exres, mwres;
      logic          out_ready;
   } txn_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [DW-1:0] rs_data, rt_data, imm;
   logic [RW-1:0] rs_addr, rt_addr, rd_addr;
   logic          alu_src;
   logic [1:0]    alu_op;
   logic [5:0]    funct;
   logic          wr_en, flush;
   logic          exmem_wr_en, memwb_wr_en;
   logic [RW-1:0] exmem_rd, memwb_rd;
   logic [DW-1:0] exmem_result, memwb_result;
   logic          out_valid, out_ready;
   logic [DW-1:0] alu_a, alu_b;
   logic [2:0]    alu_sel;
   logic [RW-1:0] out_rd;
   logic          out_wr_en, illegal;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state
   logic          m_valid;
   logic [DW-1:0] m_a, m_b;
   logic [2:0]    m_sel;
   logic [RW-1:0] m_rd;
   logic          m_wren, m_ill;
   logic          obs_ready, exp_ready;

   always #5 clk = ~clk;

   srg_id_ex_stage #(.DW(DW), .RW(RW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_in_valid     (in_valid),
      .o_in_ready     (in_ready),
      .i_rs_data      (rs_data),
      .i_rt_data      (rt_data),
      .i_imm          (imm),
      .i_rs_addr      (rs_addr),
      .i_rt_addr      (rt_addr),
      .i_rd_addr      (rd_addr),
      .i_alu_src      (alu_src),
      .i_alu_op       (alu_op),
      .i_funct        (funct),
      .i_wr_en        (wr_en),
      .i_flush        (flush),
      .i_exmem_wr_en  (exmem_wr_en),
      .i_memwb_wr_en  (memwb_wr_en),
      .i_exmem_rd     (exmem_rd),
      .i_memwb_rd     (memwb_rd),
      .i_exmem_result (exmem_result),
      .i_memwb_result (memwb_result),
      .o_out_valid    (out_valid),
      .i_out_ready    (out_ready),
      .o_alu_a        (alu_a),
      .o_alu_b        (alu_b),
      .o_alu_sel      (alu_sel),
      .o_out_rd       (out_rd),
      .o_out_wr_en    (out_wr_en),
      .o_illegal      (illegal)
   );

   // ---------------- reference model ----------------
   // Returns {illegal, sel} from the instruction-level decode table.
   function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] fn);
      if (op == 2'd0) return {1'b0, 3'b010};
      if (op == 2'd1) return {1'b0, 3'b110};
      if (op == 2'd2) begin
         if (fn == 6'd32) return {1'b0, 3'b010};
         if (fn == 6'd34) return {1'b0, 3'b110};
         if (fn == 6'd36) return {1'b0, 3'b000};
         if (fn == 6'd37) return {1'b0, 3'b001};
         if (fn == 6'd42) return {1'b0, 3'b111};
      end
      return {1'b1, 3'b010};
   endfunction

   function automatic logic [DW-1:0] ref_operand(input txn_t t, input logic [RW-1:0] src,
                                                 input logic [DW-1:0] rf);
      if (src == 0) return rf;
      if (t.exwe && t.exrd == src) return t.exres;
      if (t.mwwe && t.mwrd == src) return t.mwres;
      return rf;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_a = 0; m_b = 0; m_sel = 0; m_rd = 0; m_wren = 0; m_ill = 0;
   endtask

   function automatic txn_t idle_txn();
      txn_t t;
      t.in_valid = 0; t.rs_data = 0; t.rt_data = 0; t.imm = 0;
      t.rs = 0; t.rt = 0; t.rd = 0; t.alu_src = 0; t.alu_op = 0; t.funct = 0;
      t.wr_en = 0; t.flush = 0; t.exwe = 0; t.mwwe = 0; t.exrd = 0; t.mwrd = 0;
      t.exres = 0; t.mwres = 0; t.out_ready = 1;
      return t;
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      logic [5:0] fns [6];
      fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd7};
      t.in_valid  = ($urandom_range(0, 3) != 0);
      t.rs_data   = $urandom; t.rt_data = $urandom; t.imm = $urandom;
      t.rs        = RW'($urandom_range(0, 3));
      t.rt        = RW'($urandom_range(0, 3));
      t.rd        = RW'($urandom);
      t.alu_src   = $urandom_range(0, 1);
      t.alu_op    = 2'($urandom_range(0, 3));
      t.funct     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      t.wr_en     = $urandom_range(0, 1);
      t.flush     = ($urandom_range(0, 9) == 0);
      t.exwe      = $urandom_range(0, 1);
      t.mwwe      = $urandom_range(0, 1);
      t.exrd      = RW'($urandom_range(0, 3));
      t.mwrd      = RW'($urandom_range(0, 3));
      t.exres     = $urandom; t.mwres = $urandom;
      t.out_ready = ($urandom_range(0, 2) != 0);
      return t;
   endfunction

   // Drive one cycle of stimulus, advance the model, and land #1 after the edge.
   task automatic step(input txn_t t);
      logic [3:0] d;
      in_valid = t.in_valid; rs_data = t.rs_data; rt_data = t.rt_data; imm = t.imm;
      rs_addr = t.rs; rt_addr = t.rt; rd_addr = t.rd; alu_src = t.alu_src;
      alu_op = t.alu_op; funct = t.funct; wr_en = t.wr_en; flush = t.flush;
      exmem_wr_en = t.exwe; memwb_wr_en = t.mwwe; exmem_rd = t.exrd; memwb_rd = t.mwrd;
      exmem_result = t.exres; memwb_result = t.mwres; out_ready = t.out_ready;
      #1;
      obs_ready = in_ready;
      exp_ready = !m_valid || t.out_ready;
      if (t.flush) begin
         m_valid = 0;
      end else if (t.in_valid && exp_ready) begin
         d       = ref_decode(t.alu_op, t.funct);
         m_valid = 1;
         m_a     = ref_operand(t, t.rs, t.rs_data);
         m_b     = t.alu_src ? t.imm : ref_operand(t, t.rt, t.rt_data);
         m_sel   = d[2:0];
         m_ill   = d[3];
         m_rd    = t.rd;
         m_wren  = t.wr_en && !d[3];
      end else if (m_valid && t.out_ready) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      step(idle_txn());
      rst_n = 0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      n_checks++;
      if ({out_valid, alu_a, alu_b, alu_sel, out_rd, out_wr_en, illegal} !== 75'd0)
         $display("FAIL reset_outputs: got v=%b a=%h b=%h sel=%b rd=%0d we=%b ill=%b want all zero",
                  out_valid, alu_a, alu_b, alu_sel, out_rd, out_wr_en, illegal);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
      else n_pass++;
      rst_n = 1;
   endtask

   task automatic test_rtype_sub();
      txn_t t = idle_txn();
      t.in_valid = 1; t.rs = 3; t.rs_data = 10; t.rt = 4; t.rt_data = 7;
      t.alu_op = 2'b10; t.funct = 6'b100010; t.wr_en = 1; t.rd = 9; t.out_ready = 0;
      step(t);
      n_checks++;
      if ({out_valid, alu_sel, alu_a, alu_b, out_rd, out_wr_en, illegal} !==
          {1'b1, 3'b110, 32'd10, 32'd7, 5'd9, 1'b1, 1'b0})
         $display("FAIL rtype_sub: got v=%b sel=%b a=%0d b=%0d rd=%0d we=%b ill=%b want 1 110 10 7 9 1 0",
                  out_valid, alu_sel, alu_a, alu_b, out_rd, out_wr_en, illegal);
      else n_pass++;
      t = idle_txn();
      step(t); // drain
   endtask

   task automatic test_forward_priority();
      txn_t t = idle_txn();
      t.in_valid = 1; t.rs = 5; t.rs_data = 32'h11; t.exwe = 1; t.exrd = 5; t.exres = 32'hAA;
      t.mwwe = 1; t.mwrd = 5; t.mwres = 32'hBB;
      step(t);
      n_checks++;
      if (alu_a !== 32'hAA) $display("FAIL fwd_exmem_priority: got %h want 000000aa", alu_a);
      else n_pass++;
      t.exwe = 0;
      step(t);
      n_checks++;
      if (alu_a !== 32'hBB) $display("FAIL fwd_memwb: got %h want 000000bb", alu_a);
      else n_pass++;
      t.exwe = 1; t.rs = 0; t.exrd = 0; t.mwrd = 0; t.rs_data = 32'h33;
      step(t);
      n_checks++;
      if (alu_a !== 32'h33) $display("FAIL fwd_reg0: got %h want 00000033", alu_a);
      else n_pass++;
      // Immediate wins over a forwarding hit on rt.
      t.rt = 2; t.exrd = 2; t.rt_data = 32'h44; t.alu_src = 1; t.imm = 32'hFFFF_FFF0;
      step(t);
      n_checks++;
      if (alu_b !== 32'hFFFF_FFF0) $display("FAIL imm_over_fwd: got %h want fffffff0", alu_b);
      else n_pass++;
      t.alu_src = 0;
      step(t);
      n_checks++;
      if (alu_b !== 32'hAA) $display("FAIL fwd_rt_exmem: got %h want 000000aa", alu_b);
      else n_pass++;
      step(idle_txn());
   endtask

   task automatic test_illegal();
      txn_t t = idle_txn();
      t.in_valid = 1; t.alu_op = 2'b10; t.funct = 6'b000111; t.wr_en = 1; t.rd = 3;
      step(t);
      n_checks++;
      if ({alu_sel, illegal, out_wr_en} !== {3'b010, 1'b1, 1'b0})
         $display("FAIL illegal_funct: got sel=%b ill=%b we=%b want 010 1 0", alu_sel, illegal, out_wr_en);
      else n_pass++;
      t.alu_op = 2'b11; t.funct = 6'b100100;
      step(t);
      n_checks++;
      if ({alu_sel, illegal, out_wr_en} !== {3'b010, 1'b1, 1'b0})
         $display("FAIL illegal_aluop: got sel=%b ill=%b we=%b want 010 1 0", alu_sel, illegal, out_wr_en);
      else n_pass++;
      step(idle_txn());
   endtask

   task automatic test_stall();
      txn_t t = idle_txn();
      t.in_valid = 1; t.rs = 1; t.rs_data = 32'h100; t.out_ready = 0;
      step(t); // A captured
      t.rs_data = 32'h200;
      for (int i = 0; i < 3; i++) begin
         step(t);
         n_checks++;
         if (obs_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b want 0", i, obs_ready);
         else n_pass++;
         n_checks++;
         if ({out_valid, alu_a} !== {1'b1, 32'h100})
            $display("FAIL stall_hold[%0d]: got v=%b a=%h want 1 00000100", i, out_valid, alu_a);
         else n_pass++;
      end
      t.out_ready = 1;
      step(t);
      n_checks++;
      if (obs_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", obs_ready);
      else n_pass++;
      n_checks++;
      if ({out_valid, alu_a} !== {1'b1, 32'h200})
         $display("FAIL stall_second_capture: got v=%b a=%h want 1 00000200", out_valid, alu_a);
      else n_pass++;
      step(idle_txn());
   endtask

   task automatic test_flush();
      txn_t t = idle_txn();
      t.in_valid = 1; t.rs = 1; t.rs_data = 32'h55;
      step(t);
      t.rs_data = 32'h66; t.flush = 1;
      step(t);
      n_checks++;
      if ({out_valid, alu_a} !== {1'b0, 32'h55})
         $display("FAIL flush_valid: got v=%b a=%h want 0 00000055", out_valid, alu_a);
      else n_pass++;
      step(t); // flush while empty and in_ready=1
      n_checks++;
      if ({out_valid, alu_a} !== {1'b0, 32'h55})
         $display("FAIL flush_empty: got v=%b a=%h want 0 00000055", out_valid, alu_a);
      else n_pass++;
      step(idle_txn());
   endtask

   task automatic test_random();
      txn_t t;
      for (int i = 0; i < 400; i++) begin
         t = rand_txn();
         step(t);
         n_checks++;
         if (obs_ready !== exp_ready)
            $display("FAIL rand_in_ready[%0d]: got %b want %b", i, obs_ready, exp_ready);
         else n_pass++;
         n_checks++;
         if ({out_valid, alu_a, alu_b, alu_sel, out_rd, out_wr_en, illegal} !==
             {m_valid, m_a, m_b, m_sel, m_rd, m_wren, m_ill})
            $display("FAIL rand_out[%0d]: got v=%b a=%h b=%h sel=%b rd=%0d we=%b ill=%b want v=%b a=%h b=%h sel=%b rd=%0d we=%b ill=%b",
                     i, out_valid, alu_a, alu_b, alu_sel, out_rd, out_wr_en, illegal,
                     m_valid, m_a, m_b, m_sel, m_rd, m_wren, m_ill);
         else n_pass++;
      end
      step(idle_txn());
   endtask

   task automatic test_async_reset();
      txn_t t = idle_txn();
      t.in_valid = 1; t.alu_op = 2'b01; t.rs = 1; t.rs_data = 32'h77; t.out_ready = 0;
      step(t);
      step(t); // stalled with out_valid=1
      #3;
      rst_n = 0;
      #1;
      n_checks++;
      if ({out_valid, alu_sel, alu_a} !== {1'b0, 3'b000, 32'd0})
         $display("FAIL async_reset: got v=%b sel=%b a=%h want 0 000 00000000", out_valid, alu_sel, alu_a);
      else n_pass++;
      model_reset();
      @(posedge clk); #2;
      rst_n = 1;
      t.rs_data = 32'h88; t.out_ready = 1;
      step(t);
      n_checks++;
      if ({out_valid, alu_sel, alu_a} !== {1'b1, 3'b110, 32'h88})
         $display("FAIL post_reset_capture: got v=%b sel=%b a=%h want 1 110 00000088", out_valid, alu_sel, alu_a);
      else n_pass++;
      step(idle_txn());
   endtask

   initial begin
      rst_n = 0;
      model_reset();
      test_reset();
      test_rtype_sub();
      test_forward_priority();
      test_illegal();
      test_stall();
      test_flush();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_srg_id_ex_stage
`default_nettype wire
